seq_restoring_divider: RTL and testbench

- Sequential radix-2 restoring divider. It is the inverse companion of the team's sequential Booth multiplier and sits alongside it in the arithmetic datapath.
- Computes quotient and remainder of a WIDTH-bit dividend by a WIDTH-bit divisor, in signed or unsigned mode, producing one quotient bit per clock.
- Uses a start/busy/done handshake. Results are held stable until the next accepted start.

---
 rtl/seq_restoring_divider.sv | 121 ++++++++++++
 tb/tb_seq_restoring_divider.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/seq_restoring_divider.sv
// Sequential radix-2 restoring divider, one quotient bit per clock.
// Signed operands are reduced to magnitudes on capture, divided unsigned,
// and the signs are reapplied in a single fix-up cycle.
//
// state | meaning
// IDLE  | waiting for start; results held
// RUN   | one restoring iteration per clock, counter counts down to 1
// FIX   | sign correction, result write, done pulse
module seq_restoring_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sign_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state;
  logic [WIDTH-1:0] r_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] d_reg;
  logic [WIDTH-1:0] dvd_cap;
  logic [CNT_W-1:0] cnt;
  logic             neg_q;
  logic             neg_r;
  logic             dz;

  logic [WIDTH+1:0] trial;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] dvd_abs;
  logic [WIDTH-1:0] dvs_abs;

  // Operand magnitudes; negating MIN wraps to 2^(WIDTH-1), which is the
  // correct unsigned magnitude.
  always_comb begin
    dvd_abs = (sign_mode && dividend[WIDTH-1]) ? (~dividend + 1'b1) : dividend;
    dvs_abs = (sign_mode && divisor[WIDTH-1])  ? (~divisor + 1'b1)  : divisor;
  end

  // Trial subtraction of the divisor from the shifted partial remainder;
  // the extra top bit acts as the borrow flag (set means T < 0).
  always_comb begin
    r_shift = {r_reg[WIDTH-2:0], q_reg[WIDTH-1]};
    trial   = {1'b0, r_reg, q_reg[WIDTH-1]} - {2'b00, d_reg};
  end

  // Control FSM and datapath registers; outputs only change in FIX or reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      cnt         <= '0;
      r_reg       <= '0;
      q_reg       <= '0;
      d_reg       <= '0;
      dvd_cap     <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dz          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy    <= 1'b1;
            dvd_cap <= dividend;
            r_reg   <= '0;
            q_reg   <= dvd_abs;
            d_reg   <= dvs_abs;
            neg_q   <= sign_mode & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_r   <= sign_mode & dividend[WIDTH-1];
            dz      <= (divisor == '0);
            if (divisor == '0) begin
              state <= FIX;
            end else begin
              cnt   <= CNT_W'(WIDTH);
              state <= RUN;
            end
          end
        end
        RUN: begin
          // A borrow means the shifted remainder is kept (restored).
          if (!trial[WIDTH+1]) r_reg <= trial[WIDTH-1:0];
          else                 r_reg <= r_shift;
          q_reg <= {q_reg[WIDTH-2:0], ~trial[WIDTH+1]};
          cnt   <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= FIX;
        end
        FIX: begin
          if (dz) begin
            quotient  <= '1;
            remainder <= dvd_cap;
          end else begin
            quotient  <= neg_q ? (~q_reg + 1'b1) : q_reg;
            remainder <= neg_r ? (~r_reg + 1'b1) : r_reg;
          end
          div_by_zero <= dz;
          busy        <= 1'b0;
          done        <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Bench for seq_restoring_divider: directed corner cases plus random
// operands compared against a plain-arithmetic reference model.
module tb_seq_restoring_divider;

  localparam int W = 32;
  localparam int N_RAND = 1500;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         sign_mode = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int checks = 0;
  int failures = 0;

  seq_restoring_divider #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .sign_mode(sign_mode),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: truncating division in 64-bit arithmetic, then cut to W bits.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic z);
    longint sa, sb, qq, rr;
    if (b == '0) begin
      q = '1;
      r = a;
      z = 1'b1;
    end else begin
      if (sm) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
      end else begin
        sa = longint'({32'd0, a});
        sb = longint'({32'd0, b});
      end
      qq = sa / sb;
      rr = sa % sb;
      q = qq[W-1:0];
      r = rr[W-1:0];
      z = 1'b0;
    end
  endfunction

  // Issue one operation (caller is away from the clock edge, DUT in IDLE).
  // poke >= 0 re-pulses start with 1/1 that many cycles into the operation.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm,
                       input int poke);
    logic [W-1:0] eq, er;
    logic ez;
    int n;
    int exp_lat;
    model(a, b, sm, eq, er, ez);
    exp_lat = (b == '0) ? 1 : W + 1;
    start = 1'b1;
    dividend = a;
    divisor = b;
    sign_mode = sm;
    @(posedge clk); #1;
    start = 1'b0;
    dividend = $urandom;
    divisor = $urandom;
    sign_mode = $urandom_range(0, 1);
    check("busy_after_start", {63'd0, busy}, 64'd1);
    n = 0;
    while (done !== 1'b1 && n < 60) begin
      start = (n == poke);
      if (n == poke) begin
        dividend = 1;
        divisor = 1;
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    check("latency", 64'(n), 64'(exp_lat));
    check("quotient", {32'd0, quotient}, {32'd0, eq});
    check("remainder", {32'd0, remainder}, {32'd0, er});
    check("div_by_zero", {63'd0, div_by_zero}, {63'd0, ez});
    check("busy_in_done", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    logic [W-1:0] a, b, q_hold;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_quotient", {32'd0, quotient}, 64'd0);
    check("rst_remainder", {32'd0, remainder}, 64'd0);
    check("rst_dbz", {63'd0, div_by_zero}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    do_op(32'd100, 32'd7, 1'b0, -1);
    check("u100_7_q", {32'd0, quotient}, 64'd14);
    check("u100_7_r", {32'd0, remainder}, 64'd2);
    do_op(-32'sd100, 32'd7, 1'b1, -1);
    check("sm100_7_q", {32'd0, quotient}, 64'h0FFFFFFF2);
    check("sm100_7_r", {32'd0, remainder}, 64'h0FFFFFFFE);
    do_op(32'd100, -32'sd7, 1'b1, -1);
    check("s100_m7_q", {32'd0, quotient}, 64'h0FFFFFFF2);
    check("s100_m7_r", {32'd0, remainder}, 64'd2);
    do_op(32'd5, 32'd0, 1'b0, -1);
    check("dz_q", {32'd0, quotient}, 64'h0FFFFFFFF);
    check("dz_r", {32'd0, remainder}, 64'd5);
    check("dz_flag", {63'd0, div_by_zero}, 64'd1);
    do_op(32'd9, 32'd3, 1'b0, -1);
    check("after_dz_flag", {63'd0, div_by_zero}, 64'd0);
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, -1);
    check("ovf_q", {32'd0, quotient}, 64'h080000000);
    check("ovf_r", {32'd0, remainder}, 64'd0);
    do_op(32'hFFFF_FFFF, 32'd1, 1'b0, -1);
    do_op(32'd50, 32'd5, 1'b0, 10);
    check("ignored_start_q", {32'd0, quotient}, 64'd10);

    // results hold while idle
    q_hold = quotient;
    repeat (5) @(posedge clk);
    #1;
    check("hold_q", {32'd0, quotient}, {32'd0, q_hold});
    check("hold_done", {63'd0, done}, 64'd0);

    // reset in the middle of an operation
    start = 1'b1; dividend = 50; divisor = 5; sign_mode = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    check("mid_rst_done", {63'd0, done}, 64'd0);
    check("mid_rst_q", {32'd0, quotient}, 64'd0);
    check("mid_rst_r", {32'd0, remainder}, 64'd0);
    do_op(32'd1000, 32'd33, 1'b0, -1);
    check("post_rst_q", {32'd0, quotient}, 64'd30);
    check("post_rst_r", {32'd0, remainder}, 64'd10);

    for (int i = 0; i < N_RAND; i++) begin
      a = $urandom;
      if ($urandom_range(0, 15) == 0) a = 32'h8000_0000;
      b = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 31) == 0) b = '0;
      if ($urandom_range(0, 31) == 0) b = '1;
      do_op(a, b, 1'($urandom_range(0, 1)), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
